// File: rtl/jpeg_bit_window.sv
// Byte-stream to left-aligned 64-bit look-ahead window for the JPEG decoder.
// Removes FF 00 stuffing in scan data, consumes 0..64 bits per cycle and re-aligns to byte boundaries.
module jpeg_bit_window #(
  parameter int BUF_W = 128,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             destuff_en,
  input  logic             shift_en,
  input  logic [6:0]       shift_len,
  input  logic             align_req,
  output logic [63:0]      bit_out,
  output logic             bit_avali,
  output logic [7:0]       fill,
  output logic             stuff_seen,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] stuff_cnt
);

  typedef enum logic [0:0] {
    NORM   = 1'b0,
    GOT_FF = 1'b1
  } state_t;

  localparam logic [8:0] LOAD_MAX = 9'(BUF_W - 8);

  logic [BUF_W-1:0] buf_r;
  logic [7:0]       fill_r;
  state_t           state_r;
  logic             stuff_seen_r;
  logic [CNT_W-1:0] byte_cnt_r;
  logic [CNT_W-1:0] stuff_cnt_r;

  logic [6:0]       shift_amt_s;
  logic             do_shift_s;
  logic             do_align_s;
  logic [6:0]       eff_shift_s;
  logic [8:0]       post_fill_s;
  logic             accept_s;
  logic             drop_s;
  logic             write_s;
  logic [BUF_W-1:0] shifted_s;
  logic [BUF_W-1:0] ins_s;
  logic [BUF_W-1:0] buf_nxt_s;
  logic [8:0]       fill_nxt_s;
  state_t           state_nxt_s;

  assign bit_avali  = (fill_r >= 8'd64);
  assign bit_out    = buf_r[BUF_W-1 -: 64];
  assign fill       = fill_r;
  assign stuff_seen = stuff_seen_r;
  assign byte_cnt   = byte_cnt_r;
  assign stuff_cnt  = stuff_cnt_r;
  assign din_ready  = (post_fill_s <= LOAD_MAX);

  // Consume/align amount for this cycle; consume wins over align and needs a full window.
  always_comb begin
    shift_amt_s = (shift_len > 7'd64) ? 7'd64 : shift_len;
    do_shift_s  = shift_en & bit_avali;
    do_align_s  = align_req & ~shift_en;
    if (do_shift_s) begin
      eff_shift_s = shift_amt_s;
    end else if (do_align_s) begin
      eff_shift_s = {4'd0, fill_r[2:0]};
    end else begin
      eff_shift_s = 7'd0;
    end
    post_fill_s = {1'b0, fill_r} - {2'b00, eff_shift_s};
  end

  // Destuffing decision: a 00 following FF in scan data is dropped, not written.
  always_comb begin
    accept_s    = din_valid & din_ready;
    drop_s      = 1'b0;
    state_nxt_s = state_r;
    if (accept_s) begin
      if (!destuff_en) begin
        state_nxt_s = NORM;
      end else begin
        case (state_r)
          NORM: begin
            state_nxt_s = (din == 8'hFF) ? GOT_FF : NORM;
          end
          GOT_FF: begin
            if (din == 8'h00) begin
              drop_s      = 1'b1;
              state_nxt_s = NORM;
            end else if (din == 8'hFF) begin
              state_nxt_s = GOT_FF;
            end else begin
              state_nxt_s = NORM;
            end
          end
          default: begin
            state_nxt_s = NORM;
          end
        endcase
      end
    end else begin
      state_nxt_s = state_r;
    end
    write_s = accept_s & ~drop_s;
  end

  // Next buffer: shift out consumed bits, then append the new byte after the remaining fill.
  always_comb begin
    shifted_s = buf_r << eff_shift_s;
    ins_s     = {din, {(BUF_W-8){1'b0}}} >> post_fill_s;
    if (write_s) begin
      buf_nxt_s  = shifted_s | ins_s;
      fill_nxt_s = post_fill_s + 9'd8;
    end else begin
      buf_nxt_s  = shifted_s;
      fill_nxt_s = post_fill_s;
    end
  end

  // Window, fill, destuff state and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_r        <= {BUF_W{1'b0}};
      fill_r       <= 8'd0;
      state_r      <= NORM;
      stuff_seen_r <= 1'b0;
      byte_cnt_r   <= {CNT_W{1'b0}};
      stuff_cnt_r  <= {CNT_W{1'b0}};
    end else if (clr) begin
      buf_r        <= {BUF_W{1'b0}};
      fill_r       <= 8'd0;
      state_r      <= NORM;
      stuff_seen_r <= 1'b0;
      byte_cnt_r   <= {CNT_W{1'b0}};
      stuff_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      buf_r        <= buf_nxt_s;
      fill_r       <= fill_nxt_s[7:0];
      state_r      <= state_nxt_s;
      stuff_seen_r <= drop_s;
      byte_cnt_r   <= byte_cnt_r + (accept_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}});
      stuff_cnt_r  <= stuff_cnt_r + (drop_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}});
    end
  end

endmodule
